burst_scheduler: RTL and testbench
==================================

Name: burst_scheduler

Overview:
Controller that sequences the SignalGenerator drive source into interrupter bursts for the coil driver. It accepts drive-period and burst on/off configuration over a valid/ready handshake, programs the generator's period at safe boundaries and holds or restarts the generator phase. It gates the generator output into N-cycles-on / M-cycles-off bursts, with an immediate fault kill. It sits between the host config/register path and the SignalGenerator → gate-driver path.

Parameters:
DEFAULT_PERIOD, 100, generator period loaded at reset (clock ticks).
DEFAULT_ON, 8, drive cycles per burst after reset.
DEFAULT_OFF, 992, idle drive cycles between bursts after reset.
MIN_PERIOD, 2, smaller cfg_period values are clamped up to this.

Ports:
clock  in  1  system clock; all state on rising edge.
reset  in  1  asynchronous, active-low reset.
enable  in  1  level; run bursts while high.
fault  in  1  level; overcurrent/interlock kill.
cfg_valid  in  1  config word offered.
cfg_ready  out  1  config slot free.
cfg_period  in  32  generator period, in ticks.
cfg_on  in  16  drive cycles per burst.
cfg_off  in  16  drive cycles between bursts.
gen_cycle_end  in  1  generator cycle_end.
gen_out  in  1  generator out (half-cycle square).
gen_period  out  32  to generator period_in.
gen_set_period  out  1  one-cycle load strobe to generator set_period.
gen_reset  out  1  active-high synchronous hold/restart to the generator reset.
drive  out  1  gated drive to the gate driver.
state_out  out  3  current FSM state encoding.
fault_latched  out  1  high while in FAULT.

Behaviour:
- Reset values:
  - state = IDLE.
  - active and pending registers = {DEFAULT_PERIOD, DEFAULT_ON, DEFAULT_OFF}.
  - gen_period = DEFAULT_PERIOD.
  - gen_set_period = 0, gen_reset = 1, drive = 0, cfg_ready = 1, fault_latched = 0.
- Config handshake:
  - Transfer on cfg_valid & cfg_ready. Capture into pending registers and set pend.
  - cfg_ready = ~pend, registered, so it drops the cycle after the transfer.
  - Period clamp: period < MIN_PERIOD → MIN_PERIOD.
- Apply pending:
  - When: in IDLE (next cycle), or on the entry into each BURST_ON (START, or OFF→ON).
  - Action: active ← pending, gen_period ← pending period, gen_set_period pulses 1 cycle, pend clears.
  - Never applied mid-burst or mid-off.
- FSM states: IDLE, START, BURST_ON, BURST_OFF, DRAIN, FAULT.
- IDLE:
  - gen_reset = 1, drive = 0.
  - enable & ~fault → START.
- START (1 cycle):
  - gen_reset = 1, apply pending, clear cycle counter.
  - → BURST_ON. The generator restarts at counter 0, so the first drive edge is phase-aligned.
- BURST_ON:
  - gen_reset = 0, drive = gen_out & ~fault (combinational kill).
  - Count gen_cycle_end pulses.
  - On the pulse where count = on−1: → BURST_OFF if off ≠ 0. If off = 0, stay in BURST_ON with counter cleared and pending applied (continuous mode).
  - on = 0: skip BURST_ON; go straight to BURST_OFF (drive never asserts).
  - enable low → DRAIN.
- DRAIN:
  - drive = gen_out & ~fault until the next gen_cycle_end, then → IDLE.
  - Never truncates a half-cycle.
- BURST_OFF:
  - drive = 0, generator keeps running.
  - After off gen_cycle_end pulses: → BURST_ON, applying pending, counter cleared.
  - enable low → IDLE next cycle.
- FAULT:
  - fault = 1 in any state → FAULT on the next edge; drive is already 0 combinationally that cycle.
  - In FAULT: gen_reset = 1, drive = 0, fault_latched = 1.
  - Exit to IDLE only when fault = 0 and enable = 0.
  - fault has priority over enable and config.
- Counters are 16-bit and compare with equality; no wrap is possible since they clear on every transition.
- Reset assertion mid-burst clears state immediately (async). drive is 0 with no glitch wider than the reset propagation.

Decomposition:
- Package burst_pkg holds:
  - state_t enum (3 bits, fixed encodings: IDLE=0, START=1, BURST_ON=2, BURST_OFF=3, DRAIN=4, FAULT=5).
  - burst_cfg_t struct {period[31:0], on[15:0], off[15:0]}.
  - The MIN_PERIOD default.
- One sub-module, cfg_slot: a single-entry valid/ready holding register with clamp and an apply strobe, reusable for other coil parameters.

Test Plan:
- Reset, enable = 1, defaults → gen_set_period pulses once with gen_period = 100. Expect drive toggling for exactly 8 cycle_end periods, then 992 periods low, then repeat.
- cfg {period=10, on=3, off=2} sent mid-burst → cfg_ready low next cycle. The new period is applied only at the next BURST_ON entry; the bench sees 3 on, 2 off at period 10.
- cfg on=0 off=5 → drive stays 0 indefinitely while enabled. cfg on=4 off=0 → continuous drive with no gap.
- fault asserted in the middle of a high drive half-cycle → drive = 0 the same cycle, then FAULT/fault_latched. Dropping fault with enable high keeps FAULT; dropping enable too → IDLE.
- enable dropped mid-BURST_ON → drive continues to the next gen_cycle_end, then IDLE with gen_reset = 1. Enable dropped in BURST_OFF → IDLE in 1 cycle.
- cfg_period = 1 → gen_period = 2. reset pulsed low mid-burst → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/burst_pkg.sv
// Shared types and constants for the burst scheduler and its config slot.
package burst_pkg;

  // Fixed encodings; state_out exposes these directly.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StBurstOn  = 3'd2,
    StBurstOff = 3'd3,
    StDrain    = 3'd4,
    StFault    = 3'd5
  } state_t;

  typedef struct packed {
    logic [31:0] period;
    logic [15:0] on;
    logic [15:0] off;
  } burst_cfg_t;

  localparam int unsigned MinPeriodDefault = 2;

  // Generator periods below the minimum cannot produce a half-cycle square.
  function automatic logic [31:0] clamp_period(input logic [31:0] p, input logic [31:0] min_p);
    return (p < min_p) ? min_p : p;
  endfunction

endpackage

// File: rtl/cfg_slot.sv
// Single-entry valid/ready holding register for a burst configuration word.
// A word is captured (period clamped) when the slot is free and held as
// pending until the owner pulses apply.
module cfg_slot
  import burst_pkg::*;
#(
  parameter int unsigned RESET_PERIOD = 100,
  parameter int unsigned RESET_ON     = 8,
  parameter int unsigned RESET_OFF    = 992,
  parameter int unsigned MIN_PERIOD   = MinPeriodDefault
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  burst_cfg_t in_cfg,
  input  logic       apply,
  output burst_cfg_t pending,
  output logic       pend
);

  burst_cfg_t pending_q;
  logic       pend_q;
  logic       xfer;

  assign xfer     = in_valid & in_ready;
  assign in_ready = ~pend_q;
  assign pending  = pending_q;
  assign pend     = pend_q;

  // Capture on transfer; a fresh capture wins over an apply of the old word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q.period <= 32'(RESET_PERIOD);
      pending_q.on     <= 16'(RESET_ON);
      pending_q.off    <= 16'(RESET_OFF);
      pend_q           <= 1'b0;
    end else begin
      if (xfer) begin
        pending_q.period <= clamp_period(in_cfg.period, 32'(MIN_PERIOD));
        pending_q.on     <= in_cfg.on;
        pending_q.off    <= in_cfg.off;
      end
      if (xfer) begin
        pend_q <= 1'b1;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/burst_scheduler.sv
// Interrupter burst controller: programs the signal generator period at safe
// boundaries and gates its output into on/off bursts with an immediate fault kill.
module burst_scheduler
  import burst_pkg::*;
#(
  parameter int unsigned DEFAULT_PERIOD = 100,
  parameter int unsigned DEFAULT_ON     = 8,
  parameter int unsigned DEFAULT_OFF    = 992,
  parameter int unsigned MIN_PERIOD     = MinPeriodDefault
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        fault,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_period,
  input  logic [15:0] cfg_on,
  input  logic [15:0] cfg_off,
  input  logic        gen_cycle_end,
  input  logic        gen_out,
  output logic [31:0] gen_period,
  output logic        gen_set_period,
  output logic        gen_reset,
  output logic        drive,
  output logic [2:0]  state_out,
  output logic        fault_latched
);

  state_t     state_q, state_d;
  burst_cfg_t active_q;
  burst_cfg_t pending;
  burst_cfg_t cfg_word;
  logic       pend;
  logic       apply;
  logic       set_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] eff_on;

  assign cfg_word = {cfg_period, cfg_on, cfg_off};

  cfg_slot #(
    .RESET_PERIOD(DEFAULT_PERIOD),
    .RESET_ON    (DEFAULT_ON),
    .RESET_OFF   (DEFAULT_OFF),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_cfg_slot (
    .clock   (clock),
    .reset   (reset),
    .in_valid(cfg_valid),
    .in_ready(cfg_ready),
    .in_cfg  (cfg_word),
    .apply   (apply),
    .pending (pending),
    .pend    (pend)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Active config, period strobe and cycle counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_q.period <= 32'(DEFAULT_PERIOD);
      active_q.on     <= 16'(DEFAULT_ON);
      active_q.off    <= 16'(DEFAULT_OFF);
      set_q           <= 1'b0;
      cnt_q           <= '0;
    end else begin
      if (apply) begin
        active_q <= pending;
      end
      set_q <= apply;
      cnt_q <= cnt_d;
    end
  end

  // Next-state, counter and apply decision; fault overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    apply   = 1'b0;
    // Burst length that will be in force after an apply-if-pending.
    eff_on  = pend ? pending.on : active_q.on;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable) begin
          state_d = StStart;
        end else begin
          apply = pend;
        end
      end
      StStart: begin
        // Always reload so the restarted generator runs the intended period.
        cnt_d   = '0;
        apply   = 1'b1;
        state_d = (pending.on == '0) ? StBurstOff : StBurstOn;
      end
      StBurstOn: begin
        if (!enable) begin
          state_d = gen_cycle_end ? StIdle : StDrain;
        end else if (gen_cycle_end) begin
          if (cnt_q == active_q.on - 16'd1) begin
            cnt_d = '0;
            if (active_q.off != '0) begin
              state_d = StBurstOff;
            end else begin
              // Continuous mode: each new burst is an entry point for pending config.
              apply = pend;
              if (eff_on == '0) begin
                state_d = StBurstOff;
              end
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StBurstOff: begin
        if (!enable) begin
          state_d = StIdle;
        end else if ((active_q.off == '0) ||
                     (gen_cycle_end && (cnt_q == active_q.off - 16'd1))) begin
          cnt_d   = '0;
          apply   = pend;
          state_d = (eff_on == '0) ? StBurstOff : StBurstOn;
        end else if (gen_cycle_end) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDrain: begin
        if (gen_cycle_end) begin
          state_d = StIdle;
        end
      end
      StFault: begin
        cnt_d = '0;
        if (!fault && !enable) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (fault) begin
      state_d = StFault;
      apply   = 1'b0;
      cnt_d   = '0;
    end
  end

  // Outputs; drive is killed combinationally by fault.
  always_comb begin
    gen_reset      = (state_q == StIdle) || (state_q == StStart) || (state_q == StFault);
    drive          = ((state_q == StBurstOn) || (state_q == StDrain)) && gen_out && !fault;
    fault_latched  = (state_q == StFault);
    state_out      = state_q;
    gen_period     = active_q.period;
    gen_set_period = set_q;
  end

endmodule

// File: tb/tb_burst_scheduler.sv
// Self-checking bench for burst_scheduler with a behavioural signal generator.
module tb_burst_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        fault = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_period = '0;
  logic [15:0] cfg_on = '0;
  logic [15:0] cfg_off = '0;
  logic        gen_cycle_end;
  logic        gen_out;
  logic [31:0] gen_period;
  logic        gen_set_period;
  logic        gen_reset;
  logic        drive;
  logic [2:0]  state_out;
  logic        fault_latched;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  burst_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .fault         (fault),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_period    (cfg_period),
    .cfg_on        (cfg_on),
    .cfg_off       (cfg_off),
    .gen_cycle_end (gen_cycle_end),
    .gen_out       (gen_out),
    .gen_period    (gen_period),
    .gen_set_period(gen_set_period),
    .gen_reset     (gen_reset),
    .drive         (drive),
    .state_out     (state_out),
    .fault_latched (fault_latched)
  );

  // Signal generator: counter 0..period-1, high for the first half.
  logic [31:0] gcnt = '0;
  logic [31:0] gper = 32'd100;
  always @(posedge clock) begin
    if (gen_set_period) gper <= gen_period;
    if (gen_reset) gcnt <= '0;
    else if (gcnt >= gper - 1) gcnt <= '0;
    else gcnt <= gcnt + 1;
  end
  assign gen_out       = gcnt < (gper >> 1);
  assign gen_cycle_end = gcnt >= gper - 1;

  // Records, per generator cycle, whether drive was ever high in it.
  bit mon_en = 1'b0;
  bit seen = 1'b0;
  bit act_q[$];
  always @(negedge clock) begin
    if (!mon_en) seen <= 1'b0;
    else if (gen_cycle_end) begin
      act_q.push_back(seen | drive);
      seen <= 1'b0;
    end else if (drive) seen <= 1'b1;
  end

  // Reference: generator cycle k of a run is a drive cycle iff k mod (on+off) < on.
  function automatic bit exp_act(input int k, input int on, input int off);
    if (on + off == 0) return 1'b0;
    return (k % (on + off)) < on;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_act(input int n, input string tag);
    int t = 0;
    while (act_q.size() < n && t < 20000) begin
      @(negedge clock);
      t++;
    end
    chk(tag, 32'(act_q.size() >= n), 32'd1);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int t = 0;
    while (state_out != s && t < 2000) begin
      @(negedge clock);
      t++;
    end
    chk(tag, 32'(state_out), 32'(s));
  endtask

  task automatic send_cfg(input int p, input int on, input int off);
    int t = 0;
    cfg_period = 32'(p);
    cfg_on     = 16'(on);
    cfg_off    = 16'(off);
    cfg_valid  = 1'b1;
    while (!cfg_ready && t < 5000) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    cfg_valid = 1'b0;
    chk("cfg_ready_drop", 32'(cfg_ready), 32'd0);
  endtask

  // Load a config from IDLE, then run and compare n generator cycles.
  task automatic run_cfg(input int p, input int on, input int off, input int n);
    mon_en = 1'b0;
    enable = 1'b0;
    wait_state(3'd0, "run_idle");
    send_cfg(p, on, off);
    @(negedge clock);
    chk("idle_apply_period", gen_period, 32'((p < 2) ? 2 : p));
    act_q.delete();
    mon_en = 1'b1;
    enable = 1'b1;
    wait_act(n, "run_timeout");
    for (int k = 0; k < n; k++) chk("burst_pattern", 32'(act_q[k]), 32'(exp_act(k, on, off)));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, 32'(state_out), 32'd0);
    chk(tag, gen_period, 32'd100);
    chk(tag, 32'(gen_set_period), 32'd0);
    chk(tag, 32'(gen_reset), 32'd1);
    chk(tag, 32'(drive), 32'd0);
    chk(tag, 32'(cfg_ready), 32'd1);
    chk(tag, 32'(fault_latched), 32'd0);
  endtask

  initial begin
    int t;
    int k;
    int p;
    int on;
    int off;

    // Reset values.
    repeat (2) @(negedge clock);
    chk_reset_vals("reset_vals");
    reset = 1'b1;
    @(negedge clock);

    // Defaults: one period load of 100, then 8 on / 992 off.
    act_q.delete();
    mon_en = 1'b1;
    enable = 1'b1;
    @(negedge clock);
    chk("start_state", 32'(state_out), 32'd1);
    @(negedge clock);
    chk("set_pulse", 32'(gen_set_period), 32'd1);
    chk("default_period", gen_period, 32'd100);
    @(negedge clock);
    chk("set_pulse_end", 32'(gen_set_period), 32'd0);
    wait_act(3, "default_timeout");
    send_cfg(10, 3, 2);
    wait_act(13, "default_timeout");
    for (int i = 0; i < 13; i++) chk("default_pattern", 32'(act_q[i]), 32'(exp_act(i, 8, 992)));
    chk("no_mid_apply", gen_period, 32'd100);
    chk("in_burst_off", 32'(state_out), 32'd3);

    // Enable dropped in BURST_OFF: IDLE next cycle, then pending applied there.
    mon_en = 1'b0;
    enable = 1'b0;
    @(negedge clock);
    chk("off_to_idle", 32'(state_out), 32'd0);
    @(negedge clock);
    chk("idle_apply", gen_period, 32'd10);
    chk("ready_back", 32'(cfg_ready), 32'd1);

    // Config sent mid-burst takes effect at the next burst entry.
    act_q.delete();
    mon_en = 1'b1;
    enable = 1'b1;
    wait_act(1, "switch_timeout");
    send_cfg(6, 2, 3);
    wait_act(15, "switch_timeout");
    for (int i = 0; i < 15; i++)
      chk("switch_pattern", 32'(act_q[i]),
          32'((i < 5) ? exp_act(i, 3, 2) : exp_act(i - 5, 2, 3)));
    chk("switch_period", gen_period, 32'd6);

    // Never-on and continuous modes.
    run_cfg(4, 0, 5, 12);
    run_cfg(4, 4, 0, 12);

    // Enable dropped mid-BURST_ON drains to the end of the generator cycle.
    run_cfg(10, 3, 2, 2);
    mon_en = 1'b0;
    t = 0;
    while (!(state_out == 3'd2 && gcnt == 0 && drive) && t < 1000) begin
      @(negedge clock);
      t++;
    end
    chk("drain_sync", 32'(state_out == 3'd2 && gcnt == 0 && drive), 32'd1);
    enable = 1'b0;
    @(negedge clock);
    k = 1;
    chk("drain_drive", 32'(drive), 32'd1);
    while (state_out != 3'd0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("drain_len", 32'(k), 32'd10);
    chk("drain_gen_reset", 32'(gen_reset), 32'd1);
    chk("drain_drive_off", 32'(drive), 32'd0);

    // Enable dropped in BURST_OFF.
    enable = 1'b1;
    wait_state(3'd3, "reach_off");
    enable = 1'b0;
    @(negedge clock);
    chk("off_drop_idle", 32'(state_out), 32'd0);

    // Fault mid high half-cycle.
    enable = 1'b1;
    t = 0;
    while (!drive && t < 1000) begin
      @(negedge clock);
      t++;
    end
    chk("fault_sync", 32'(drive), 32'd1);
    fault = 1'b1;
    #1;
    chk("fault_kill", 32'(drive), 32'd0);
    @(negedge clock);
    chk("fault_state", 32'(state_out), 32'd5);
    chk("fault_latched", 32'(fault_latched), 32'd1);
    chk("fault_gen_reset", 32'(gen_reset), 32'd1);
    fault = 1'b0;
    repeat (3) @(negedge clock);
    chk("fault_hold_enable", 32'(state_out), 32'd5);
    enable = 1'b0;
    @(negedge clock);
    chk("fault_exit", 32'(state_out), 32'd0);
    chk("fault_unlatched", 32'(fault_latched), 32'd0);

    // Period clamp.
    send_cfg(1, 2, 2);
    @(negedge clock);
    chk("clamp", gen_period, 32'd2);

    // Randomised configs against the reference pattern.
    for (int i = 0; i < 6; i++) begin
      p   = int'($urandom_range(12, 0));
      on  = int'($urandom_range(4, 0));
      off = int'($urandom_range(4, 0));
      run_cfg(p, on, off, 12);
    end

    // Asynchronous reset mid-burst.
    mon_en = 1'b0;
    t = 0;
    while (!drive && t < 2000) begin
      @(negedge clock);
      t++;
    end
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clock);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
